// File: rtl/sim_run_pkg.sv
// ---------------------------------------------------------------------------
// sim_run_pkg
//
// Shared types and width helpers for the simulation run controller and for
// any monitor that decodes its outputs.
//
//   reason_t : why the run ended (3-bit code seen on sim_run_ctrl.reason)
//   state_t  : run controller phases
//   lane_w   : width of a lane index for an N-lane datapath (at least 1 bit)
//   count_w  : width able to hold a popcount of N lanes (0..N)
//   ctr_w    : width of a counter that must reach 'limit' (at least 1 bit)
// ---------------------------------------------------------------------------
package sim_run_pkg;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        HALT     = 3'd1,
        ERROR    = 3'd2,
        TIMEOUT  = 3'd3,
        DEADLOCK = 3'd4
    } reason_t;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        DRAIN      = 2'd2,
        DONE       = 2'd3
    } state_t;

    // A single-lane design still needs a 1-bit index port.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    function automatic int ctr_w(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/lane_popcount.sv
// ---------------------------------------------------------------------------
// lane_popcount
//
// Purely combinational lane summariser shared by the run controller and the
// retire monitor.
//
// Parameters:
//   NUM_CH       number of lanes
// Ports:
//   commit_valid in  NUM_CH   per-lane retire strobes
//   halt         in  NUM_CH   per-lane halt flags
//   commit_cnt   out CNT_W    number of set commit_valid bits
//   any_halt     out 1        at least one lane is halting
//   halt_idx     out LANE_W   index of the lowest halting lane (0 if none)
// ---------------------------------------------------------------------------
module lane_popcount
    import sim_run_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int LANE_W = lane_w(NUM_CH),
    parameter int CNT_W  = count_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] commit_valid,
    input  logic [NUM_CH-1:0] halt,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic              any_halt,
    output logic [LANE_W-1:0] halt_idx
);

    // Retire popcount.
    always_comb begin
        commit_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            commit_cnt = commit_cnt + CNT_W'(commit_valid[i]);
        end
    end

    // Walking from the top lane down lets the lowest set lane win.
    always_comb begin
        halt_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (halt[i]) begin
                halt_idx = LANE_W'(i);
            end
        end
    end

    assign any_halt = |halt;

endmodule

// File: rtl/sim_run_ctrl.sv
// ---------------------------------------------------------------------------
// sim_run_ctrl
//
// Run controller for the top-level simulation harness. Sequences the DUT
// reset, then watches for lane halts, error sources, a programmable cycle
// budget and a commit-progress watchdog. Produces a one-cycle 'finish' pulse
// that the bench turns into $finish, plus the end reason and run statistics.
//
// Parameters:
//   NUM_CH        commit/halt lanes
//   NUM_ERR       error sources
//   TIMEOUT_W     width of timeout budget and cycle counter
//   RST_CYCLES    cycles dut_rst is held after rst_n release
//   DRAIN_CYCLES  cycles between the first error and finish
//   STALL_LIMIT   cycles without any commit before DEADLOCK (0 disables)
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   timeout_cycles  run budget, captured when leaving RESET_HOLD (0 disables)
//   halt            per-lane halt
//   commit_valid    per-lane retire strobe
//   err             per-source error level
//   dut_rst         active-high DUT reset
//   running         high in RUN and DRAIN
//   finish          one-cycle pulse on entry to DONE
//   done            high in DONE
//   reason          reason_t end code
//   err_seen        sticky error mask
//   halt_lane       lowest halting lane index
//   cycle_count     RUN/DRAIN cycles, saturating
//   commit_count    total retired instructions, wrapping
// ---------------------------------------------------------------------------
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int NUM_ERR      = 3,
    parameter int TIMEOUT_W    = 32,
    parameter int RST_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 5,
    parameter int STALL_LIMIT  = 100000,
    localparam int LANE_W      = lane_w(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic [NUM_CH-1:0]    halt,
    input  logic [NUM_CH-1:0]    commit_valid,
    input  logic [NUM_ERR-1:0]   err,
    output logic                 dut_rst,
    output logic                 running,
    output logic                 finish,
    output logic                 done,
    output logic [2:0]           reason,
    output logic [NUM_ERR-1:0]   err_seen,
    output logic [LANE_W-1:0]    halt_lane,
    output logic [TIMEOUT_W-1:0] cycle_count,
    output logic [63:0]          commit_count
);

    localparam int CNT_W    = count_w(NUM_CH);
    localparam int RST_W    = ctr_w(RST_CYCLES);
    localparam int DRAIN_W  = ctr_w(DRAIN_CYCLES);
    localparam int STALL_W  = ctr_w(STALL_LIMIT);
    // RST_CYCLES of 0 behaves like 1: RESET_HOLD always lasts one posedge.
    localparam int RST_LAST = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;

    state_t               state_q,    state_d;
    reason_t              reason_q,   reason_d;
    logic [NUM_ERR-1:0]   err_seen_q, err_seen_d;
    logic [LANE_W-1:0]    lane_q,     lane_d;
    logic [RST_W-1:0]     rst_cnt_q,  rst_cnt_d;
    logic [DRAIN_W-1:0]   drain_q,    drain_d;
    logic [TIMEOUT_W-1:0] tmo_q,      tmo_d;
    logic [STALL_W-1:0]   stall_q,    stall_d;
    logic [TIMEOUT_W-1:0] cycle_q,    cycle_d;
    logic [63:0]          commit_q,   commit_d;
    logic                 finish_q,   finish_d;

    logic [CNT_W-1:0]     lane_commits;
    logic                 any_halt;
    logic [LANE_W-1:0]    low_halt;
    logic                 active;
    logic [STALL_W-1:0]   stall_next;

    lane_popcount #(
        .NUM_CH (NUM_CH),
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W)
    ) u_lanes (
        .commit_valid (commit_valid),
        .halt         (halt),
        .commit_cnt   (lane_commits),
        .any_halt     (any_halt),
        .halt_idx     (low_halt)
    );

    assign active = (state_q == RUN) || (state_q == DRAIN);

    // Stall counter candidate for this cycle; held at 0 when the watchdog
    // is disabled so it can never wrap into a false trigger.
    always_comb begin
        stall_next = '0;
        if (commit_valid == '0 && STALL_LIMIT != 0) begin
            stall_next = stall_q + STALL_W'(1);
        end
    end

    // Next-state and datapath update. Every register holds by default;
    // DONE therefore freezes everything until rst_n asserts.
    always_comb begin
        state_d    = state_q;
        reason_d   = reason_q;
        err_seen_d = err_seen_q;
        lane_d     = lane_q;
        rst_cnt_d  = rst_cnt_q;
        drain_d    = drain_q;
        tmo_d      = tmo_q;
        stall_d    = stall_q;
        cycle_d    = cycle_q;
        commit_d   = commit_q;
        finish_d   = 1'b0;

        if (active) begin
            if (cycle_q != '1) begin
                cycle_d = cycle_q + TIMEOUT_W'(1);
            end
            commit_d = commit_q + 64'(lane_commits);
        end

        case (state_q)
            RESET_HOLD: begin
                if (rst_cnt_q >= RST_W'(RST_LAST)) begin
                    state_d = RUN;
                    tmo_d   = timeout_cycles;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            RUN: begin
                // Errors are recorded even when a halt wins the same cycle.
                err_seen_d = err_seen_q | err;
                stall_d    = stall_next;
                if (tmo_q != '0) begin
                    tmo_d = tmo_q - TIMEOUT_W'(1);
                end

                if (any_halt) begin
                    state_d  = DONE;
                    reason_d = HALT;
                    lane_d   = low_halt;
                end else if (err != '0) begin
                    reason_d = ERROR;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_W'(DRAIN_CYCLES);
                    end
                end else if (tmo_q == TIMEOUT_W'(1)) begin
                    // Budget loaded as N reaches 1 on the Nth RUN posedge.
                    state_d  = DONE;
                    reason_d = TIMEOUT;
                end else if (STALL_LIMIT != 0 &&
                             stall_next >= STALL_W'(STALL_LIMIT)) begin
                    state_d  = DONE;
                    reason_d = DEADLOCK;
                end
            end

            DRAIN: begin
                // Halts, budget and stall are deliberately ignored here so
                // late error sources still get reported.
                err_seen_d = err_seen_q | err;
                if (drain_q <= DRAIN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end

            DONE: begin
            end

            default: begin
                state_d = RESET_HOLD;
            end
        endcase

        finish_d = (state_d == DONE) && (state_q != DONE);
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_HOLD;
            reason_q   <= NONE;
            err_seen_q <= '0;
            lane_q     <= '0;
            rst_cnt_q  <= '0;
            drain_q    <= '0;
            tmo_q      <= '0;
            stall_q    <= '0;
            cycle_q    <= '0;
            commit_q   <= '0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            reason_q   <= reason_d;
            err_seen_q <= err_seen_d;
            lane_q     <= lane_d;
            rst_cnt_q  <= rst_cnt_d;
            drain_q    <= drain_d;
            tmo_q      <= tmo_d;
            stall_q    <= stall_d;
            cycle_q    <= cycle_d;
            commit_q   <= commit_d;
            finish_q   <= finish_d;
        end
    end

    assign dut_rst      = (state_q == RESET_HOLD);
    assign running      = active;
    assign done         = (state_q == DONE);
    assign finish       = finish_q;
    assign reason       = reason_q;
    assign err_seen     = err_seen_q;
    assign halt_lane    = lane_q;
    assign cycle_count  = cycle_q;
    assign commit_count = commit_q;

endmodule
